// File: rtl/pc_link_fifo.sv
// pc_link_fifo: DEPTH-entry buffered rts/cts four-phase link from the trace/JTAG datapath to the host PC.
// Optional macro OVERFLOW_MARKER_EN: enqueue a {MARKER_TAG, drop count} word once space frees after drops.
module pc_link_fifo #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DROP_CNT_WIDTH = 16,
  parameter logic [3:0]  MARKER_TAG     = 4'hF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      flush,
  input  logic                      wr_valid,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      wr_ready,
  output logic [DATA_WIDTH-1:0]     pc_data,
  output logic                      rts,
  input  logic                      cts,
  output logic [ADDR_WIDTH:0]       level,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int unsigned         PAY_W    = DATA_WIDTH - 4;
  localparam int unsigned         WIDE_W   = (PAY_W > DROP_CNT_WIDTH) ? PAY_W : DROP_CNT_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, PRESENT, WAIT_LOW} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [DATA_WIDTH-1:0]     r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]     r_wr_ptr;
  logic [ADDR_WIDTH-1:0]     r_rd_ptr;
  logic [ADDR_WIDTH:0]       r_level;
  logic                      r_full;
  logic                      r_rts;
  logic [DATA_WIDTH-1:0]     r_pc_data;
  logic                      r_overflow;
  logic [DROP_CNT_WIDTH-1:0] r_drop_count;
  logic [SYNC_STAGES-1:0]    r_cts_sync;

  logic                      w_cts_s;
  logic                      w_load;
  logic                      w_pop;
  logic                      w_marker;
  logic                      w_wr_ok;
  logic                      w_drop;
  logic                      w_push;
  logic [DATA_WIDTH-1:0]     w_push_data;
  logic [ADDR_WIDTH:0]       w_level_nxt;
  logic [DROP_CNT_WIDTH-1:0] w_dc_base;
  logic [DROP_CNT_WIDTH-1:0] w_dc_nxt;
  logic [WIDE_W-1:0]         w_dc_wide;
  logic [PAY_W-1:0]          w_payload;
  logic [DATA_WIDTH-1:0]     w_marker_word;

  assign w_cts_s = r_cts_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && (r_level != '0) && !w_cts_s) begin
          w_load      = 1'b1;
          w_state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (w_cts_s) begin
          w_pop       = 1'b1;
          w_state_nxt = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!w_cts_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // flush aborts any handshake; a PC still holding cts must release it first
    if (flush) begin
      w_load      = 1'b0;
      w_pop       = 1'b0;
      w_state_nxt = w_cts_s ? WAIT_LOW : IDLE;
    end
  end

  always_comb begin
    w_dc_wide = WIDE_W'(r_drop_count);
    if ((w_dc_wide >> PAY_W) != '0) w_payload = '1;
    else                            w_payload = w_dc_wide[PAY_W-1:0];
    w_marker_word = {MARKER_TAG, w_payload};
  end

`ifdef OVERFLOW_MARKER_EN
  assign w_marker = (r_drop_count != '0) && !r_full && !w_load && !flush;
`else
  assign w_marker = 1'b0;
`endif

  // wr_ready is forced low for the whole time reset is held
  assign wr_ready    = reset && !r_full && !w_marker;
  assign w_wr_ok     = wr_valid && wr_ready && !flush;
  assign w_drop      = wr_valid && !wr_ready && !flush;
  assign w_push      = w_wr_ok || w_marker;
  assign w_push_data = w_marker ? w_marker_word : wr_data;
  assign w_level_nxt = r_level + (ADDR_WIDTH+1)'(w_push) - (ADDR_WIDTH+1)'(w_pop);

  always_comb begin
    w_dc_base = w_marker ? '0 : r_drop_count;
    w_dc_nxt  = w_dc_base;
    if (w_drop && (w_dc_base != '1)) w_dc_nxt = w_dc_base + DROP_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_full       <= 1'b0;
      r_rts        <= 1'b0;
      r_pc_data    <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_full       <= 1'b0;
      r_rts        <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      r_level      <= w_level_nxt;
      r_full       <= (w_level_nxt == LVL_FULL);
      r_drop_count <= w_dc_nxt;
      if (w_drop) r_overflow <= 1'b1;
      if (w_load) begin
        r_pc_data <= r_mem[r_rd_ptr];
        r_rts     <= 1'b1;
      end else if (w_pop) begin
        r_rts     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cts_sync <= '0;
    else        r_cts_sync <= {r_cts_sync[SYNC_STAGES-2:0], cts};
  end

  assign pc_data    = r_pc_data;
  assign rts        = r_rts;
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_pc_link_fifo.sv
// Self-checking bench for pc_link_fifo: directed table, hand sequences and a randomized run
// against a queue-based reference model.
module tb_pc_link_fifo;

  localparam int unsigned DW     = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = 4;
  localparam int unsigned SS     = 2;
  localparam int unsigned DCW    = 5;
  localparam int unsigned DC_MAX = (1 << DCW) - 1;

  logic           clk      = 1'b0;
  logic           reset    = 1'b1;
  logic           enable   = 1'b0;
  logic           flush    = 1'b0;
  logic           wr_valid = 1'b0;
  logic [DW-1:0]  wr_data  = '0;
  logic           cts      = 1'b0;
  logic           wr_ready;
  logic [DW-1:0]  pc_data;
  logic           rts;
  logic [AW:0]    level;
  logic           overflow;
  logic [DCW-1:0] drop_count;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  pc_link_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .SYNC_STAGES(SS),
    .DROP_CNT_WIDTH(DCW), .MARKER_TAG(4'hF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .pc_data(pc_data), .rts(rts), .cts(cts), .level(level),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue, PC-side handshake phase as 0 idle / 1 presenting / 2 awaiting cts low
  logic [DW-1:0] mq[$];
  logic          m_rts;
  logic [DW-1:0] m_pc;
  logic          m_ovf;
  int unsigned   m_dc;
  logic          m_sync[SS];
  int unsigned   m_mode;

  function automatic void model_reset();
    mq.delete();
    m_rts = 1'b0; m_pc = '0; m_ovf = 1'b0; m_dc = 0; m_mode = 0;
    for (int unsigned i = 0; i < SS; i++) m_sync[i] = 1'b0;
  endfunction

  function automatic logic m_loading();
    return (m_mode == 0) && enable && (mq.size() != 0) && !m_sync[SS-1];
  endfunction

  function automatic logic m_marker();
`ifdef OVERFLOW_MARKER_EN
    return (m_dc != 0) && (mq.size() < DEPTH) && !m_loading() && !flush;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_wr_ready();
    return reset && (mq.size() < DEPTH) && !m_marker();
  endfunction

  function automatic void model_step();
    logic          cs, ld, mk, rdy;
    int unsigned   base;
    logic [DW-1:0] mword;
    if (!reset) begin
      model_reset();
      return;
    end
    cs    = m_sync[SS-1];
    ld    = m_loading();
    mk    = m_marker();
    rdy   = m_wr_ready();
    mword = {4'hF, 12'((m_dc > 4095) ? 4095 : m_dc)};
    for (int unsigned i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = cts;
    if (flush) begin
      mq.delete();
      m_rts = 1'b0; m_ovf = 1'b0; m_dc = 0;
      m_mode = cs ? 2 : 0;
      return;
    end
    if (ld) begin
      m_pc = mq[0]; m_rts = 1'b1; m_mode = 1;
    end else if (m_mode == 1 && cs) begin
      void'(mq.pop_front()); m_rts = 1'b0; m_mode = 2;
    end else if (m_mode == 2 && !cs) begin
      m_mode = 0;
    end
    base = mk ? 0 : m_dc;
    if (mk) mq.push_back(mword);
    if (wr_valid && rdy) mq.push_back(wr_data);
    if (wr_valid && !rdy) begin
      m_ovf = 1'b1;
      if (base < DC_MAX) base++;
    end
    m_dc = base;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("level",      32'(level),      32'(mq.size()));
    chk("rts",        32'(rts),        32'(m_rts));
    chk("pc_data",    32'(pc_data),    32'(m_pc));
    chk("wr_ready",   32'(wr_ready),   32'(m_wr_ready()));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("drop_count", 32'(drop_count), m_dc);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    enable = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; cts = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    idle(2);
    reset = 1'b1;
    cycle();
  endtask

  task automatic wait_rts(input logic v, input string nm);
    int unsigned k = 0;
    while (rts !== v && k < 60) begin
      cycle();
      k++;
    end
    chk(nm, 32'(rts), 32'(v));
  endtask

  task automatic handshake(input logic [DW-1:0] d, input string nm);
    wait_rts(1'b1, {nm, "_rts_hi"});
    chk({nm, "_data"}, 32'(pc_data), 32'(d));
    cts = 1'b1;
    wait_rts(1'b0, {nm, "_rts_lo"});
    cts = 1'b0;
  endtask

  task automatic write_words(input logic [DW-1:0] base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + DW'(i);
      cycle();
    end
    wr_valid = 1'b0;
  endtask

  typedef struct {
    logic          en;
    logic          wv;
    logic [DW-1:0] wd;
    logic          c;
    logic          e_rts;
    logic [DW-1:0] e_pc;
    int unsigned   e_lvl;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #2;
    // single-word handshake: rts one cycle after write, pop SYNC_STAGES+1 edges after cts rises
    tbl[0]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1};
    tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1};
    tbl[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1};
    tbl[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 0};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 0};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 0};
    tbl[8]  = '{1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0, 16'h1234, 1};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hABCD, 1};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hABCD, 1};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hABCD, 1};
    tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hABCD, 0};
    tbl[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hABCD, 0};
    tbl[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hABCD, 0};
    tbl[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hABCD, 0};

    do_reset();
    chk("reset_level", 32'(level), 0);
    chk("reset_pc", 32'(pc_data), 0);
    for (int unsigned i = 0; i < 16; i++) begin
      enable = tbl[i].en; wr_valid = tbl[i].wv; wr_data = tbl[i].wd; cts = tbl[i].c;
      cycle();
      chk($sformatf("tbl%0d_rts", i), 32'(rts), 32'(tbl[i].e_rts));
      chk($sformatf("tbl%0d_pc", i), 32'(pc_data), 32'(tbl[i].e_pc));
      chk($sformatf("tbl%0d_lvl", i), 32'(level), tbl[i].e_lvl);
    end
    wr_valid = 1'b0;

    // 17 back-to-back writes with no PC activity, then drain in order
    do_reset();
    enable = 1'b1;
    write_words(16'h0000, 17);
    cycle();
    chk("fill_level", 32'(level), 16);
    chk("fill_ready", 32'(wr_ready), 0);
    chk("fill_ovf", 32'(overflow), 1);
    chk("fill_drops", 32'(drop_count), 1);
    for (int unsigned i = 0; i < 16; i++) handshake(DW'(i), $sformatf("drain%0d", i));

    // pop and write in the same cycle at full: write refused
    do_reset();
    enable = 1'b1;
    write_words(16'h0100, 16);
    cycle();
    cts = 1'b1;
    idle(2);
    wr_valid = 1'b1; wr_data = 16'hBEEF;
    chk("popwr_ready_pre", 32'(wr_ready), 0);
    cycle();
    wr_valid = 1'b0; cts = 1'b0;
    chk("popwr_level", 32'(level), 15);
    chk("popwr_drops", 32'(drop_count), 1);
    chk("popwr_rts", 32'(rts), 0);
`ifdef OVERFLOW_MARKER_EN
    chk("popwr_ready_post", 32'(wr_ready), 0);
`else
    chk("popwr_ready_post", 32'(wr_ready), 1);
`endif
    idle(3);

    // flush while presenting with cts high; write in flush cycle discarded
    do_reset();
    enable = 1'b1;
    write_words(16'h00A1, 2);
    wait_rts(1'b1, "flush_rts_hi");
    cts = 1'b1;
    idle(2);
    flush = 1'b1; wr_valid = 1'b1; wr_data = 16'h00EE;
    cycle();
    flush = 1'b0; wr_valid = 1'b0;
    chk("flush_level", 32'(level), 0);
    chk("flush_rts", 32'(rts), 0);
    chk("flush_drops", 32'(drop_count), 0);
    write_words(16'h00A3, 1);
    idle(2);
    chk("flush_waitlow_rts", 32'(rts), 0);
    cts = 1'b0;
    handshake(16'h00A3, "flush_after");

    // enable low holds presentation; reset mid-handshake
    do_reset();
    write_words(16'h00C0, 3);
    idle(5);
    chk("en0_rts", 32'(rts), 0);
    chk("en0_level", 32'(level), 3);
    enable = 1'b1;
    for (int unsigned i = 0; i < 3; i++) handshake(16'h00C0 + DW'(i), $sformatf("en1_%0d", i));
    write_words(16'h00D0, 1);
    wait_rts(1'b1, "rst_mid_rts_hi");
    cts = 1'b1;
    cycle();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_rst_rts", 32'(rts), 0);
    chk("async_rst_ready", 32'(wr_ready), 0);
    check_all();
    cts = 1'b0;
    idle(2);
    reset = 1'b1;
    cycle();

    // drop counter saturation
    do_reset();
    write_words(16'h0200, 16);
    wr_valid = 1'b1;
    idle(40);
    wr_valid = 1'b0;
    chk("sat_drops", 32'(drop_count), DC_MAX);
    chk("sat_ovf", 32'(overflow), 1);

`ifdef OVERFLOW_MARKER_EN
    do_reset();
    write_words(16'h0300, 16);
    wr_valid = 1'b1;
    idle(5);
    wr_valid = 1'b0;
    chk("mk_drops_pre", 32'(drop_count), 5);
    enable = 1'b1;
    wait_rts(1'b1, "mk_rts_hi");
    cts = 1'b1;
    wait_rts(1'b0, "mk_rts_lo");
    cts = 1'b0;
    cycle();
    chk("mk_drops_post", 32'(drop_count), 0);
    chk("mk_level", 32'(level), 16);
    chk("mk_ovf", 32'(overflow), 1);
    for (int unsigned i = 1; i < 16; i++) handshake(16'h0300 + DW'(i), $sformatf("mk_drain%0d", i));
    handshake(16'hF005, "mk_word");
`endif

    // randomized traffic with a PC that follows the protocol at random speed
    do_reset();
    for (int unsigned ph = 0; ph < 15; ph++) begin
      int unsigned wprob = $urandom_range(1, 9);
      for (int unsigned c = 0; c < 200; c++) begin
        enable   = ($urandom % 8) != 0;
        wr_valid = ($urandom % 10) < wprob;
        wr_data  = DW'($urandom);
        flush    = ($urandom % 150) == 0;
        if (rts && !cts && ($urandom % 3) == 0)      cts = 1'b1;
        else if (!rts && cts && ($urandom % 3) == 0) cts = 1'b0;
        cycle();
      end
    end
    flush = 1'b0; wr_valid = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
